pipe_stage_ctrl: RTL and testbench
==================================

Name: pipe_stage_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives the write-enable and bubble/flush inputs of the pc, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, which are built from write-enable registers with reset/init value.
- Resolves stall and flush requests: load-use hazard, taken branch, multi-cycle mul/div in EX, data-memory wait, and exception.
- Owns the mul/div occupancy counter.

Parameters:
- MD_LATENCY, 32, total EX-stall cycles for a mul/div op (legal 2..2^CNT_WIDTH-1).
- CNT_WIDTH, 6, width of occupancy counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_load_use  in  1  ID instruction reads the destination of a load currently in EX.
- i_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- i_md_start  in  1  EX holds a mul/div op; stays high while that op sits in EX.
- i_mem_stall  in  1  data memory not ready; MEM must hold.
- i_exception  in  1  MEM-stage exception; redirect to handler.
- o_pc_we  out  1  pc register write enable.
- o_ifid_we  out  1  IF/ID write enable.
- o_idex_we  out  1  ID/EX write enable.
- o_exmem_we  out  1  EX/MEM write enable.
- o_memwb_we  out  1  MEM/WB write enable.
- o_ifid_flush, o_idex_flush, o_exmem_flush  out  1 each  with matching we=1, stage register loads its init value (bubble) instead of data.
- o_md_busy  out  1  high while state==MD_BUSY.
- o_state  out  2  RUN=0, MD_BUSY=1, MD_DONE=2.

Behaviour:
- Registered: state (2b) and cnt (CNT_WIDTH). Reset: state=RUN, cnt=0.
- All o_* are combinational from state and inputs.
- Out of reset with all inputs 0: all we=1, all flush=0, o_md_busy=0, o_state=0.
- "ADV" means all five we=1. "FREEZE" means all five we=0, all flush=0.
- Priority, evaluated every cycle: exception > mem_stall > md > branch > load_use.
- Exception, any state: ADV, ifid/idex/exmem flush=1; next state RUN, cnt=0.
- mem_stall (no exception), any state: FREEZE; state and cnt hold.
- RUN + i_md_start:
  - pc/ifid/idex we=0; exmem we=1 with exmem_flush=1; memwb we=1.
  - cnt<=MD_LATENCY-1; next MD_BUSY.
- MD_BUSY:
  - Same outputs as the start cycle.
  - cnt>1: cnt<=cnt-1. cnt==1: cnt<=0, next MD_DONE.
  - Total front-end stall = MD_LATENCY cycles (start + MD_LATENCY-1 busy).
- MD_DONE: i_md_start ignored; branch/load_use evaluated as in RUN; next RUN. ADV occurs in the same cycle, so the mul/div result moves to MEM.
- RUN/MD_DONE + i_branch_taken: ADV, ifid_flush=1, idex_flush=1 (two wrong-path instrs killed). i_load_use is ignored.
- RUN/MD_DONE + i_load_use only: pc/ifid we=0; idex we=1 with idex_flush=1; exmem/memwb we=1. Exactly one bubble per hazard, because the load leaves EX next cycle.
- Otherwise: ADV, no flush.
- Flush outputs are never asserted with their we=0.
- Async reset mid-MD_BUSY returns to RUN immediately; the counter is discarded.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with i_md_start=1, then release with inputs 0 → during reset state=RUN, o_md_busy=0; after release all we=1, all flush=0.
- Load-use: i_load_use=1 for one cycle → that cycle pc_we=ifid_we=0, idex_we=1, idex_flush=1; next cycle ADV.
- Branch plus load-use in the same cycle → ADV with ifid_flush=idex_flush=1, no stall.
- Mul/div with MD_LATENCY=4:
  - Cycle 0: i_md_start=1 held → cycles 0-3 pc_we=0, exmem_flush=1.
  - o_md_busy=1 in cycles 1-3; cycle 4 MD_DONE with ADV.
  - Cycle 5 RUN.
- i_mem_stall=1 in MD_BUSY at cnt=2 for 3 cycles → FREEZE for 3 cycles with cnt held at 2; MD_DONE is delayed by 3 cycles.
- i_exception during MD_BUSY → that cycle ADV with three flushes; next state RUN, o_md_busy=0. Exception together with mem_stall → the exception wins.

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Owns the mul/div occupancy counter; all stage controls are decoded combinationally from state and requests.
module pipe_stage_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_load_use,
    input  logic       i_branch_taken,
    input  logic       i_md_start,
    input  logic       i_mem_stall,
    input  logic       i_exception,
    output logic       o_pc_we,
    output logic       o_ifid_we,
    output logic       o_idex_we,
    output logic       o_exmem_we,
    output logic       o_memwb_we,
    output logic       o_ifid_flush,
    output logic       o_idex_flush,
    output logic       o_exmem_flush,
    output logic       o_md_busy,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MD_LOAD = CNT_WIDTH'(MD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 md_hold;

    // MD_DONE deliberately ignores i_md_start so the finished op can leave EX.
    assign md_hold = (state == RUN && i_md_start) || (state == MD_BUSY);

    always_comb begin
        o_pc_we       = 1'b1;
        o_ifid_we     = 1'b1;
        o_idex_we     = 1'b1;
        o_exmem_we    = 1'b1;
        o_memwb_we    = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;

        if (i_exception) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            state_nxt     = RUN;
            cnt_nxt       = '0;
        end else if (i_mem_stall) begin
            o_pc_we    = 1'b0;
            o_ifid_we  = 1'b0;
            o_idex_we  = 1'b0;
            o_exmem_we = 1'b0;
            o_memwb_we = 1'b0;
        end else if (md_hold) begin
            // Hold the front end; EX/MEM takes bubbles while the op iterates in EX.
            o_pc_we       = 1'b0;
            o_ifid_we     = 1'b0;
            o_idex_we     = 1'b0;
            o_exmem_flush = 1'b1;
            if (state == RUN) begin
                cnt_nxt   = MD_LOAD;
                state_nxt = MD_BUSY;
            end else if (cnt > CNT_ONE) begin
                cnt_nxt = cnt - CNT_ONE;
            end else begin
                cnt_nxt   = '0;
                state_nxt = MD_DONE;
            end
        end else if (i_branch_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            state_nxt    = RUN;
        end else if (i_load_use) begin
            o_pc_we      = 1'b0;
            o_ifid_we    = 1'b0;
            o_idex_flush = 1'b1;
            state_nxt    = RUN;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign o_md_busy = (state == MD_BUSY);
    assign o_state   = state;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl with MD_LATENCY=4: directed hazard cases plus a random phase.
module tb_pipe_stage_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_load_use, i_branch_taken, i_md_start, i_mem_stall, i_exception;
    logic       o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we;
    logic       o_ifid_flush, o_idex_flush, o_exmem_flush, o_md_busy;
    logic [1:0] o_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts stall cycles taken so far rather than cycles remaining.
    int m_state   = 0;
    int m_elapsed = 0;
    logic [10:0] exp_q[$];
    logic [1:0]  seen_state;

    pipe_stage_ctrl #(.MD_LATENCY(LAT), .CNT_WIDTH(6)) dut (
        .clk(clk), .resetn(resetn),
        .i_load_use(i_load_use), .i_branch_taken(i_branch_taken),
        .i_md_start(i_md_start), .i_mem_stall(i_mem_stall), .i_exception(i_exception),
        .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we), .o_idex_we(o_idex_we),
        .o_exmem_we(o_exmem_we), .o_memwb_we(o_memwb_we),
        .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush), .o_exmem_flush(o_exmem_flush),
        .o_md_busy(o_md_busy), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pc,ifid,idex,exmem,memwb we, ifid,idex,exmem flush, busy, state}
    function automatic logic [10:0] model_out(input logic ld, br, md, ms, ex);
        logic [4:0] we;
        logic [2:0] fl;
        if (ex)                                      begin we = 5'b11111; fl = 3'b111; end
        else if (ms)                                 begin we = 5'b00000; fl = 3'b000; end
        else if ((m_state == 0 && md) || m_state == 1) begin we = 5'b00011; fl = 3'b001; end
        else if (br)                                 begin we = 5'b11111; fl = 3'b110; end
        else if (ld)                                 begin we = 5'b00111; fl = 3'b010; end
        else                                         begin we = 5'b11111; fl = 3'b000; end
        return {we, fl, (m_state == 1), 2'(m_state)};
    endfunction

    task automatic model_step(input logic md, ms, ex);
        if (ex) begin
            m_state = 0; m_elapsed = 0;
        end else if (ms) begin
            // hold
        end else if (m_state == 0 && md) begin
            m_elapsed = 1; m_state = 1;
        end else if (m_state == 1) begin
            m_elapsed++;
            if (m_elapsed == LAT) begin m_state = 2; m_elapsed = 0; end
        end else begin
            m_state = 0;
        end
    endtask

    // Called at posedge+1: drive, push expectation, compare mid-cycle, advance model, wait next edge.
    task automatic cyc(input logic ld, br, md, ms, ex);
        logic [10:0] got, exp;
        i_load_use = ld; i_branch_taken = br; i_md_start = md; i_mem_stall = ms; i_exception = ex;
        exp_q.push_back(model_out(ld, br, md, ms, ex));
        #3;
        got = {o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we,
               o_ifid_flush, o_idex_flush, o_exmem_flush, o_md_busy, o_state};
        exp = exp_q.pop_front();
        seen_state = o_state;
        check_eq("ctrl_vec", 32'(got), 32'(exp));
        check_eq("flush_without_we",
                 32'((o_ifid_flush & ~o_ifid_we) | (o_idex_flush & ~o_idex_we) | (o_exmem_flush & ~o_exmem_we)),
                 32'd0);
        model_step(md, ms, ex);
        @(posedge clk); #1;
    endtask

    initial begin
        int done_at;
        resetn = 1'b0;
        i_load_use = 0; i_branch_taken = 0; i_md_start = 1; i_mem_stall = 0; i_exception = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("reset_state", 32'(o_state), 32'd0);
            check_eq("reset_busy", 32'(o_md_busy), 32'd0);
        end
        resetn = 1'b1;
        i_md_start = 0;
        #1;
        check_eq("post_reset_we", 32'({o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we}), 32'h1f);
        check_eq("post_reset_flush", 32'({o_ifid_flush, o_idex_flush, o_exmem_flush}), 32'd0);
        @(posedge clk); #1;

        cyc(0, 0, 0, 0, 0);
        // load-use bubble then advance; branch beats load-use
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // plain mul/div: 4 stall cycles, DONE on cycle 4, RUN on cycle 5
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, (i < 4), 0, 0);
            if (i == 4) check_eq("md_done_cycle", 32'(seen_state), 32'd2);
        end
        cyc(0, 0, 0, 0, 0);
        check_eq("md_back_to_run", 32'(seen_state), 32'd0);

        // mem_stall at cnt=2 for 3 cycles delays MD_DONE by 3
        done_at = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            cyc(0, 0, 1'b1, (i >= 2 && i < 5), 0);
            if (seen_state == 2'd2) done_at = i;
        end
        check_eq("md_done_after_stall", 32'(done_at), 32'(LAT + 3));
        cyc(0, 0, 0, 0, 0);

        // exception mid-busy, alone and together with mem_stall
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        check_eq("exc_busy_cleared", 32'(o_md_busy), 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0);
        check_eq("exc_stall_run", 32'(seen_state), 32'd0);

        // MD_DONE ignores md_start and still honours branch
        for (int i = 0; i < LAT; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // async reset mid-busy
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        resetn = 1'b0;
        #1;
        check_eq("async_reset_state", 32'(o_state), 32'd0);
        check_eq("async_reset_busy", 32'(o_md_busy), 32'd0);
        i_md_start = 0;
        m_state = 0; m_elapsed = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
